// File: rtl/bit_extender_pipe_pkg.sv
// Shared types and mode codes for the immediate extender.
// Decode drives in_mode with these same EXT_* values.
package bit_extender_pipe_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO     = 2'd0,
    EXT_SIGN     = 2'd1,
    EXT_SIGN_SHL = 2'd2,
    EXT_UPPER    = 2'd3
  } ext_mode_e;

  localparam int MODE_W = 2;

endpackage

// File: rtl/bit_extender_pipe_skid_buffer_2.sv
// Generic 2-entry valid/ready register slice.
// in_ready comes straight from a flop so out_ready never reaches it.
module skid_buffer_2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         acc;
  logic         drain;

  assign acc      = in_valid & in_ready;
  assign drain    = out_valid & out_ready;
  assign in_ready = !skid_valid;

  // skid only fills while main is stalled, so it is always older than input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || drain) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (acc) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (acc) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/bit_extender_pipe.sv
// Registered immediate extender between decode and execute.
// Extension is combinational; only the result is buffered.
module bit_extender_pipe
  import bit_extender_pipe_pkg::*;
#(
  parameter int IN_W  = 7,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_imm,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_imm
);

  // casts avoid zero-width replications when IN_W == OUT_W
  function automatic logic [OUT_W-1:0] extend(
    input logic [IN_W-1:0]   imm,
    input logic [MODE_W-1:0] mode
  );
    logic [OUT_W-1:0] zx;
    logic [OUT_W-1:0] sx;
    zx     = OUT_W'(imm);
    sx     = OUT_W'($signed(imm));
    extend = zx;
    unique case (mode)
      EXT_ZERO:     extend = zx;
      EXT_SIGN:     extend = sx;
      EXT_SIGN_SHL: extend = sx << SHAMT;
      EXT_UPPER:    extend = zx << (OUT_W - IN_W);
    endcase
  endfunction

  logic [OUT_W-1:0] ext;

  assign ext = extend(in_imm, in_mode);

  skid_buffer_2 #(
    .W(OUT_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (ext),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_imm)
  );

endmodule
